// File: rtl/wb_retire_buf.sv
// Writeback retire buffer: DEPTH-entry FIFO between the memory stage and the
// register-file write port. It adds an interrupt flush, suppresses writes to
// register 0, and exposes a forwarding lookup over every pending entry.
module wb_retire_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_we,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  count
);

    logic [PC_W-1:0]   instr_q [DEPTH];
    logic [PC_W-1:0]   pc_q    [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DEPTH-1:0]  we_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshakes depend only on registered occupancy, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state pointers and occupancy; a flush discards any same-cycle push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (int_req) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state; reset empties the buffer asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload; a write to register 0 is kept as a slot with its write enable cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q <= '0;
        end else if (push && !int_req) begin
            we_q[tail_q] <= in_we && (in_addr != '0);
        end
    end

    // Payload storage needs no reset: it is only visible through occupied slots.
    always_ff @(posedge clk) begin
        if (push && !int_req) begin
            instr_q[tail_q] <= in_instr;
            pc_q[tail_q]    <= in_pc;
            data_q[tail_q]  <= in_data;
            addr_q[tail_q]  <= in_addr;
        end
    end

    // Head entry, forced to zero when the buffer is empty.
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        out_data  = '0;
        out_addr  = '0;
        out_we    = 1'b0;
        if (out_valid) begin
            out_instr = instr_q[head_q];
            out_pc    = pc_q[head_q];
            out_data  = data_q[head_q];
            out_addr  = addr_q[head_q];
            out_we    = we_q[head_q];
        end
    end

    // Forwarding walks oldest to youngest so the youngest match wins the final overwrite.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && we_q[idx] && (addr_q[idx] == fwd_addr)
                && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_wb_retire_buf.sv
module tb_wb_retire_buf;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // DEPTH=2 instance signals
    logic        a_int_req, a_in_valid, a_in_ready, a_in_we, a_out_valid, a_out_ready;
    logic        a_out_we, a_fwd_hit;
    logic [31:0] a_in_instr, a_in_pc, a_in_data, a_out_instr, a_out_pc, a_out_data, a_fwd_data;
    logic [4:0]  a_in_addr, a_out_addr, a_fwd_addr;
    logic [1:0]  a_count;

    // DEPTH=4 instance signals
    logic        b_int_req, b_in_valid, b_in_ready, b_in_we, b_out_valid, b_out_ready;
    logic        b_out_we, b_fwd_hit;
    logic [31:0] b_in_instr, b_in_pc, b_in_data, b_out_instr, b_out_pc, b_out_data, b_fwd_data;
    logic [4:0]  b_in_addr, b_out_addr, b_fwd_addr;
    logic [2:0]  b_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_retire_buf #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(2)) u2 (
        .clk(clk), .reset(reset), .int_req(a_int_req),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .in_data(a_in_data), .in_addr(a_in_addr), .in_we(a_in_we),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
        .out_pc(a_out_pc), .out_data(a_out_data), .out_addr(a_out_addr), .out_we(a_out_we),
        .fwd_addr(a_fwd_addr), .fwd_hit(a_fwd_hit), .fwd_data(a_fwd_data), .count(a_count)
    );

    wb_retire_buf #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(4)) u4 (
        .clk(clk), .reset(reset), .int_req(b_int_req),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .in_data(b_in_data), .in_addr(b_in_addr), .in_we(b_in_we),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_data(b_out_data), .out_addr(b_out_addr), .out_we(b_out_we),
        .fwd_addr(b_fwd_addr), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data), .count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [31:0] pc, input logic [4:0] ad,
                           input logic [31:0] d, input logic we, input logic rdy);
        a_in_valid  = v;
        a_in_pc     = pc;
        a_in_instr  = 32'hA000_0000 | pc;
        a_in_addr   = ad;
        a_in_data   = d;
        a_in_we     = we;
        a_out_ready = rdy;
    endtask

    initial begin
        logic [31:0] q[$];
        int pushed;
        int popped;
        int cyc;
        bit do_push;
        bit do_pop;
        bit vld;
        bit rdy;

        a_int_req = 0; a_fwd_addr = 5'd8;
        a_drive(0, 32'h0, 5'd0, 32'h0, 0, 0);
        b_int_req = 0; b_in_valid = 0; b_in_pc = 0; b_in_instr = 0; b_in_data = 0;
        b_in_addr = 0; b_in_we = 0; b_out_ready = 0; b_fwd_addr = 0;

        // reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        reset = 1'b1;
        step();
        chk("idle_count", 64'(a_count), 64'd0);
        chk("idle_in_ready", 64'(a_in_ready), 64'd1);
        chk("idle_out_valid", 64'(a_out_valid), 64'd0);
        chk("idle_out_pc", 64'(a_out_pc), 64'd0);
        chk("idle_fwd_hit", 64'(a_fwd_hit), 64'd0);
        chk("idle_fwd_data", 64'(a_fwd_data), 64'd0);

        // fill DEPTH=2
        a_drive(1, 32'h3000, 5'd8, 32'h11, 1, 0);
        step();
        chk("p1_count", 64'(a_count), 64'd1);
        chk("p1_out_pc", 64'(a_out_pc), 64'h3000);
        chk("p1_fwd_data", 64'(a_fwd_data), 64'h11);
        a_drive(1, 32'h3004, 5'd8, 32'h22, 1, 0);
        step();
        chk("full_count", 64'(a_count), 64'd2);
        chk("full_in_ready", 64'(a_in_ready), 64'd0);
        chk("full_out_pc", 64'(a_out_pc), 64'h3000);
        chk("full_out_instr", 64'(a_out_instr), 64'hA000_3000);
        chk("full_fwd_hit", 64'(a_fwd_hit), 64'd1);
        chk("full_fwd_youngest", 64'(a_fwd_data), 64'h22);
        a_fwd_addr = 5'd9;
        #1;
        chk("full_fwd_miss", 64'(a_fwd_hit), 64'd0);
        chk("full_fwd_miss_data", 64'(a_fwd_data), 64'd0);

        // full: only the pop happens, then push+pop together
        a_drive(1, 32'h3008, 5'd9, 32'h33, 1, 1);
        step();
        chk("fullpop_count", 64'(a_count), 64'd1);
        chk("fullpop_out_pc", 64'(a_out_pc), 64'h3004);
        chk("fullpop_in_ready", 64'(a_in_ready), 64'd1);
        step();
        chk("pp_count", 64'(a_count), 64'd1);
        chk("pp_out_pc", 64'(a_out_pc), 64'h3008);
        chk("pp_out_data", 64'(a_out_data), 64'h33);
        chk("pp_fwd9_hit", 64'(a_fwd_hit), 64'd1);
        a_fwd_addr = 5'd8;
        #1;
        chk("pp_fwd8_gone", 64'(a_fwd_hit), 64'd0);

        // write to register 0
        a_drive(1, 32'h300C, 5'd0, 32'h55, 1, 0);
        step();
        chk("r0_count", 64'(a_count), 64'd2);
        a_fwd_addr = 5'd0;
        #1;
        chk("r0_fwd_hit", 64'(a_fwd_hit), 64'd0);
        a_drive(0, 32'h0, 5'd0, 32'h0, 0, 1);
        step();
        chk("r0_out_pc", 64'(a_out_pc), 64'h300C);
        chk("r0_out_we", 64'(a_out_we), 64'd0);
        chk("r0_out_data", 64'(a_out_data), 64'h55);
        chk("r0_stable_count", 64'(a_count), 64'd1);

        // stall: head must hold while out_ready=0
        a_drive(0, 32'h0, 5'd0, 32'h0, 0, 0);
        step();
        chk("stall_out_pc", 64'(a_out_pc), 64'h300C);

        // fill then flush with a concurrent push
        a_drive(1, 32'h3010, 5'd3, 32'h66, 1, 0);
        step();
        chk("pf_count", 64'(a_count), 64'd2);
        a_drive(1, 32'h3014, 5'd3, 32'h77, 1, 1);
        a_int_req = 1'b1;
        step();
        a_int_req = 1'b0;
        a_fwd_addr = 5'd3;
        #1;
        chk("fl_count", 64'(a_count), 64'd0);
        chk("fl_out_valid", 64'(a_out_valid), 64'd0);
        chk("fl_in_ready", 64'(a_in_ready), 64'd1);
        chk("fl_out_pc", 64'(a_out_pc), 64'd0);
        chk("fl_out_instr", 64'(a_out_instr), 64'd0);
        chk("fl_out_data", 64'(a_out_data), 64'd0);
        chk("fl_out_addr", 64'(a_out_addr), 64'd0);
        chk("fl_out_we", 64'(a_out_we), 64'd0);
        chk("fl_fwd_hit", 64'(a_fwd_hit), 64'd0);
        a_drive(0, 32'h0, 5'd0, 32'h0, 0, 0);
        step();
        chk("fl_after_count", 64'(a_count), 64'd0);

        // DEPTH=4 streaming with random stalls against a queue model
        pushed = 0;
        popped = 0;
        cyc = 0;
        while ((pushed < 10 || popped < 10) && cyc < 300) begin
            vld = (pushed < 10) && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) != 0);
            do_push = vld && (q.size() < 4);
            do_pop = rdy && (q.size() > 0);
            chk("s4_in_ready", 64'(b_in_ready), 64'(q.size() < 4));
            if (do_pop) chk("s4_out_pc", 64'(b_out_pc), 64'(q[0]));
            b_in_valid  = vld;
            b_in_pc     = 32'h4000 + 32'(pushed * 4);
            b_in_instr  = 32'hB000_0000 + 32'(pushed);
            b_in_data   = 32'(pushed);
            b_in_addr   = 5'(pushed + 1);
            b_in_we     = 1'b1;
            b_out_ready = rdy;
            step();
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(32'h4000 + 32'(pushed * 4));
                pushed++;
            end
            chk("s4_count", 64'(b_count), 64'(q.size()));
            cyc++;
        end
        chk("s4_done_pushed", 64'(pushed), 64'd10);
        chk("s4_done_popped", 64'(popped), 64'd10);

        // DEPTH=4: partially fill, then assert reset between clock edges
        b_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1'b1;
            b_in_pc    = 32'h5000 + 32'(k * 4);
            b_in_addr  = 5'd7;
            b_in_data  = 32'h90 + 32'(k);
            step();
        end
        b_in_valid = 1'b0;
        b_fwd_addr = 5'd7;
        #1;
        chk("s4_pre_count", 64'(b_count), 64'd3);
        chk("s4_pre_out_pc", 64'(b_out_pc), 64'h5000);
        chk("s4_pre_fwd", 64'(b_fwd_data), 64'h92);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_count", 64'(b_count), 64'd0);
        chk("arst_out_valid", 64'(b_out_valid), 64'd0);
        chk("arst_out_pc", 64'(b_out_pc), 64'd0);
        chk("arst_in_ready", 64'(b_in_ready), 64'd1);
        chk("arst_fwd_hit", 64'(b_fwd_hit), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_retire_buf.md
# wb_retire_buf

Parametrised writeback retire buffer that sits between the memory stage and the register-file write port. It generalises the single-entry writeback pipeline register into a DEPTH-entry FIFO with valid/ready handshakes on both sides, a synchronous interrupt flush, suppression of writes to register 0, and a forwarding lookup across all pending entries. The forwarding lookup lets the decode stage bypass from retiring instructions.

## Interface
- DATA_W, 32: width of writeback data.
- ADDR_W, 5: register address width.
- PC_W, 32: width of PC and instruction fields.
- DEPTH, 2: number of entries; power of two, 2..8.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state immediately.
- int_req  in  1  synchronous flush request from the interrupt controller.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  buffer can accept; equals (count != DEPTH).
- in_instr, in_pc  in  PC_W each  instruction word and PC.
- in_data  in  DATA_W  writeback value.
- in_addr  in  ADDR_W  destination register.
- in_we  in  1  register write enable.
- out_valid  out  1  head entry present; equals (count != 0).
- out_ready  in  1  register file consumes the head this cycle.
- out_instr, out_pc, out_data, out_addr, out_we  out  head entry fields; all zero when empty.
- fwd_addr  in  ADDR_W  forwarding query register.
- fwd_hit  out  1  a pending entry writes fwd_addr.
- fwd_data  out  DATA_W  data of the youngest matching entry; 0 when no hit.
- count  out  clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH-entry circular buffer with head/tail pointers of clog2(DEPTH) bits, wrapping naturally at DEPTH-1 -> 0, plus an occupancy count.
- Push: in_valid && in_ready at a clock edge writes the input fields at tail; tail++ and count++.
- Stored we = in_we && (in_addr != 0). A write to register 0 is retired as a bubble-like entry with we=0 but still occupies a slot and keeps its PC and instruction.
- Pop: out_valid && out_ready at a clock edge; head++ and count--.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: in_ready=0, so no push occurs even if a pop happens in the same cycle. There is no combinational path from out_ready to in_ready.
- Empty: out_valid=0 and all out_* fields are driven to 0. out_ready is ignored.
- Flush: when int_req=1 at an edge, count, head and tail go to 0. Any push or pop in that cycle is discarded. The next cycle shows empty, with in_ready=1.
- Forwarding (combinational):
  - Search the occupied entries from youngest (tail-1) to oldest (head).
  - A match requires stored we=1 and stored addr == fwd_addr.
  - fwd_addr=0 never hits.
  - The search sees state only, not same-cycle input.
- Reset asserted: the buffer is emptied asynchronously. Reset overrides int_req and any handshake.

## Timing
- Reset values: count=0, in_ready=1, out_valid=0, all out_* fields 0, fwd_hit=0, fwd_data=0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle), with no bypass path from in_* to out_*.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- out_* fields are stable while out_valid=1 and out_ready=0.
- int_req and reset take priority over push and pop; reset acts mid-cycle, int_req at the edge.
- Every output is a function of registered state, except fwd_hit/fwd_data, which also depend combinationally on fwd_addr.

## Test plan
- Reset, then idle: count=0, in_ready=1, out_valid=0, out_pc=0, fwd_hit=0.
- Push PC 0x3000 (addr 8, data 0x11) with out_ready=0, then push PC 0x3004 (addr 8, data 0x22):
  - count=2 and in_ready=0 (DEPTH=2).
  - out_pc=0x3000.
  - fwd_addr=8 gives fwd_hit=1, fwd_data=0x22.
- At full, assert in_valid and out_ready together:
  - Only the pop occurs; count becomes 1 and out_pc=0x3004.
  - On the next edge a push and a pop occur together; count stays 1.
- Push with in_addr=0, in_we=1, data 0x55:
  - The entry appears with out_we=0.
  - fwd_addr=0 gives fwd_hit=0.
- With count=2, raise int_req for one cycle alongside in_valid=1:
  - The next cycle shows count=0, out_valid=0 and all out_* fields 0.
  - The input pushed during the flush cycle is never seen.
- DEPTH=4: perform 10 pushes and 10 pops interleaved with random stalls.
  - out_pc order matches push order across pointer wrap-around.
  - Drive reset low mid-stream: immediate empty, with no clock edge needed.
